// File: rtl/bidir_shift_pkg.sv
// bidir_shift_pkg
//   Shared definitions for the bidirectional shift register slice:
//   operation encodings, burst FSM state type and a small op decoder.
//   No ports (package).

package bidir_shift_pkg;

  // Operation encodings; also used directly as the per-bit mux select
  localparam logic [1:0] OP_HOLD = 2'b00;
  localparam logic [1:0] OP_SHR  = 2'b01;
  localparam logic [1:0] OP_SHL  = 2'b10;
  localparam logic [1:0] OP_LOAD = 2'b11;

  // Burst engine states
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  // Only the two shift directions can start a burst
  function automatic logic is_shift_op(input logic [1:0] op);
    return (op == OP_SHR) || (op == OP_SHL);
  endfunction

endpackage

// File: rtl/shift_cell.sv
// shift_cell
//   One bit of the bidirectional shift register: a 4:1 mux choosing
//   between hold, right neighbour, left neighbour and parallel data,
//   followed by a flop with asynchronous active-low reset.
// Ports:
//   clk       in   rising-edge clock
//   rst       in   asynchronous reset, active-low
//   sel       in   2-bit select using the op encoding
//   right_in  in   bit arriving on shift right (neighbour at i+1)
//   left_in   in   bit arriving on shift left (neighbour at i-1)
//   load_in   in   parallel load bit
//   q         out  stored bit

module shift_cell
  import bidir_shift_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] sel,
  input  logic       right_in,
  input  logic       left_in,
  input  logic       load_in,
  output logic       q
);

  logic d;

  // Select the next value of this bit from the op-encoded select
  always_comb begin
    d = q;
    case (sel)
      OP_HOLD: d = q;
      OP_SHR:  d = right_in;
      OP_SHL:  d = left_in;
      OP_LOAD: d = load_in;
      default: d = q;
    endcase
  end

  // Storage flop, cleared asynchronously
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= 1'b0;
    end else begin
      q <= d;
    end
  end

endmodule

// File: rtl/bidir_shift_reg.sv
// bidir_shift_reg
//   Parametrised bidirectional shift register built from WIDTH shift_cell
//   instances. Supports hold, shift right, shift left and parallel load,
//   plus a burst engine that shifts a programmed number of positions with
//   a start/busy/done handshake.
//   Optional feature: define ROTATE_EN to build the rotate mux, letting
//   rot=1 feed the bit leaving the register back in at the other end.
// Ports:
//   clk     in   rising-edge clock
//   rst     in   asynchronous reset, active-low
//   op      in   00 hold, 01 shift right, 10 shift left, 11 load
//   sin_r   in   serial input entering at MSB on shift right
//   sin_l   in   serial input entering at LSB on shift left
//   din     in   parallel load data
//   rot     in   rotate select (only meaningful with ROTATE_EN)
//   start   in   burst request, direction taken from op
//   len     in   burst shift count, saturated to WIDTH
//   q       out  register contents
//   sout_r  out  q[0]
//   sout_l  out  q[WIDTH-1]
//   busy    out  burst running
//   done    out  one-cycle pulse at burst end

module bidir_shift_reg
  import bidir_shift_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       op,
  input  logic             sin_r,
  input  logic             sin_l,
  input  logic [WIDTH-1:0] din,
  input  logic             rot,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  output logic [WIDTH-1:0] q,
  output logic             sout_r,
  output logic             sout_l,
  output logic             busy,
  output logic             done
);

  localparam logic [CNT_W-1:0] MAX_LEN = CNT_W'(WIDTH);

  state_t           state_q;
  state_t           state_d;
  logic [1:0]       dir_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] sat_len;
  logic [1:0]       cell_sel;
  logic             start_ok;
  logic             ser_r;
  logic             ser_l;

  // A burst request is only honoured in IDLE with a shift direction
  assign start_ok = start && is_shift_op(op);
  assign sat_len  = (len > MAX_LEN) ? MAX_LEN : len;

  // Serial inputs, optionally replaced by the bit leaving the register
`ifdef ROTATE_EN
  assign ser_r = rot ? q[0]       : sin_r;
  assign ser_l = rot ? q[WIDTH-1] : sin_l;
`else
  logic rot_unused;
  assign rot_unused = rot;
  assign ser_r      = sin_r;
  assign ser_l      = sin_l;
`endif

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: RUN stays until the counter has drained, so a
  // zero-length burst still spends one RUN cycle before DONE
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start_ok) state_d = ST_RUN;
      ST_RUN:  if (cnt_q == '0) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: per-bit mux select and handshake flags
  always_comb begin
    cell_sel = OP_HOLD;
    busy     = 1'b0;
    done     = 1'b0;
    case (state_q)
      ST_IDLE: cell_sel = start_ok ? OP_HOLD : op;
      ST_RUN: begin
        busy     = 1'b1;
        cell_sel = (cnt_q != '0) ? dir_q : OP_HOLD;
      end
      ST_DONE: done = 1'b1;
      default: cell_sel = OP_HOLD;
    endcase
  end

  // Burst direction and remaining-shift counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dir_q <= OP_HOLD;
      cnt_q <= '0;
    end else if (state_q == ST_IDLE && start_ok) begin
      dir_q <= op;
      cnt_q <= sat_len;
    end else if (state_q == ST_RUN && cnt_q != '0) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  // Bit array: the ends take the serial inputs, inner bits their neighbours
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    logic right_nb;
    logic left_nb;

    if (i == WIDTH - 1) begin : g_msb
      assign right_nb = ser_r;
    end else begin : g_inner_r
      assign right_nb = q[i+1];
    end

    if (i == 0) begin : g_lsb
      assign left_nb = ser_l;
    end else begin : g_inner_l
      assign left_nb = q[i-1];
    end

    shift_cell u_cell (
      .clk      (clk),
      .rst      (rst),
      .sel      (cell_sel),
      .right_in (right_nb),
      .left_in  (left_nb),
      .load_in  (din[i]),
      .q        (q[i])
    );
  end

  assign sout_r = q[0];
  assign sout_l = q[WIDTH-1];

endmodule
